dm_cache_ctrl: RTL

//  FSM that sequences the direct-mapped write-back cache (DMCache) for one CPU requester and a backing RAM.

---
 rtl/dm_cache_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dm_cache_ctrl.sv
// Sequencer for a direct-mapped write-back cache in front of a backing RAM.
// Latency: hit or clean-miss write ready 3 cycles after accept; each RAM phase adds its wait cycles.
// Backpressure: requests are sampled only in IDLE (dropped otherwise); ram_req is held until ram_ack.
module dm_cache_ctrl #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int BLOCK_ADDR_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_busy,
    output logic [1:0]            cache_cntrl,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_dataIn,
    output logic                  cache_isDirtyWrite,
    input  logic [DATA_WIDTH-1:0] cache_dataOut,
    input  logic                  cache_isHit,
    input  logic                  cache_isClean,
    input  logic [DATA_WIDTH-1:0] cache_dataOutRAM,
    input  logic [ADDR_WIDTH-1:0] cache_addrOutRAM,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_ack
);

    localparam logic [1:0] CMD_CLR   = 2'b00;
    localparam logic [1:0] CMD_CHECK = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    typedef enum logic [3:0] {
        S_CLEAR, S_IDLE, S_CHECK, S_WB, S_FILL, S_FILL_WR, S_READ, S_WRITE, S_DONE
    } state_t;

    state_t state, nxt;

    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Line index of the accepted request; the tag/index split itself happens inside DMCache.
    logic [BLOCK_ADDR_BITS-1:0] unused_line_index;
    assign unused_line_index = req_addr[BLOCK_ADDR_BITS-1:0];

    assign cache_addr = req_addr;

    function automatic logic [1:0] cmd_for(input state_t s);
        case (s)
            S_CLEAR:           cmd_for = CMD_CLR;
            S_CHECK:           cmd_for = CMD_CHECK;
            S_FILL_WR, S_WRITE: cmd_for = CMD_WRITE;
            default:           cmd_for = CMD_READ;
        endcase
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_CLEAR: nxt = S_IDLE;
            S_IDLE: begin
                if (clr_req)      nxt = S_CLEAR;
                else if (cpu_req) nxt = S_CHECK;
            end
            S_CHECK: begin
                if (cache_isHit)         nxt = req_we ? S_WRITE : S_READ;
                else if (!cache_isClean) nxt = S_WB;
                else                     nxt = req_we ? S_WRITE : S_FILL;
            end
            S_WB:                       if (ram_ack) nxt = req_we ? S_WRITE : S_FILL;
            S_FILL:                     if (ram_ack) nxt = S_FILL_WR;
            S_FILL_WR, S_READ, S_WRITE: nxt = S_DONE;
            S_DONE:                     nxt = S_IDLE;
            default:                    nxt = S_CLEAR;
        endcase
    end

    // Outputs are registered from the next state so each one is a clean Moore decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_CLEAR;
            req_we             <= 1'b0;
            req_addr           <= '0;
            req_wdata          <= '0;
            cache_cntrl        <= CMD_CLR;
            cache_dataIn       <= '0;
            cache_isDirtyWrite <= 1'b0;
            cpu_rdata          <= '0;
            cpu_ready          <= 1'b0;
            cpu_busy           <= 1'b1;
            ram_req            <= 1'b0;
            ram_we             <= 1'b0;
            ram_addr           <= '0;
            ram_wdata          <= '0;
        end else begin
            state <= nxt;

            if (state == S_IDLE && nxt == S_CHECK) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end

            // Victim is captured only at the end of CHECK; later cache outputs are not trusted.
            if (state == S_CHECK && nxt == S_WB) begin
                ram_addr  <= cache_addrOutRAM;
                ram_wdata <= cache_dataOutRAM;
            end
            if (nxt == S_FILL)
                ram_addr <= req_addr;

            if (state == S_FILL && ram_ack)
                cache_dataIn <= ram_rdata;
            if (nxt == S_WRITE)
                cache_dataIn <= req_wdata;

            if (state == S_READ)
                cpu_rdata <= cache_dataOut;
            if (state == S_FILL_WR)
                cpu_rdata <= cache_dataIn;

            cache_cntrl        <= cmd_for(nxt);
            cache_isDirtyWrite <= (nxt == S_WRITE);
            cpu_ready          <= (nxt == S_DONE);
            cpu_busy           <= (nxt != S_IDLE);
            ram_req            <= (nxt == S_WB) || (nxt == S_FILL);
            ram_we             <= (nxt == S_WB);
        end
    end

endmodule
